// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a shared single-port memory between the instruction-fetch port
// and the data port of a small in-order pipeline. One access is in flight at
// a time; the memory command is held stable until mem_ready_i, and the
// matching requester gets a one-cycle ack with the captured read data.
// A fetch cancelled by if_flush_i still completes on the memory side, but
// its data is dropped. A wait counter guards against a memory that never
// answers. When it trips, the access is abandoned and the sticky fault flag
// is raised.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i fetch request, byte address, cancel
//   if_ack_o/if_rdata_o           fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request (load/store)
//   dm_ack_o/dm_rdata_o           data completion pulse and load data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory command (registered)
//   mem_rdata_i/mem_ready_i       memory response
//   stall_o                       combinational pipeline freeze
//   fault_o                       sticky timeout flag

module mem_port_arbiter #(
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned DM_PRIORITY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_flush_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_ack_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i,
   output logic        stall_o,
   output logic        fault_o
);

   typedef enum logic [1:0] {
      IDLE,
      IF_BUSY,
      IF_DROP,
      DM_BUSY
   } state_t;

   localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
   localparam bit         DM_FIRST    = (DM_PRIORITY != 0);

   state_t     state;
   logic [9:0] wait_cnt;
   logic [9:0] wait_inc;
   logic       timeout_hit;
   logic       if_vis;
   logic       dm_vis;
   logic       grant_if;
   logic       grant_dm;

   // A requester being acked this cycle still holds its level request;
   // masking it prevents an immediate duplicate grant. A flush also hides
   // a same-cycle fetch request.
   always_comb begin
      if_vis   = if_req_i & ~if_flush_i & ~if_ack_o;
      dm_vis   = dm_req_i & ~dm_ack_o;
      grant_dm = dm_vis & (DM_FIRST | ~if_vis);
      grant_if = if_vis & ~grant_dm;
   end

   // Saturating increment; the fault decision uses the incremented value so
   // that exactly TIMEOUT unanswered cycles trip it.
   always_comb begin
      wait_inc    = (wait_cnt == '1) ? wait_cnt : wait_cnt + 10'd1;
      timeout_hit = (wait_inc >= TIMEOUT_CNT);
   end

   assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o) | (state == IF_DROP);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         dm_ack_o    <= 1'b0;
         dm_rdata_o  <= '0;
         fault_o     <= 1'b0;
      end else begin
         if_ack_o <= 1'b0;
         dm_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               // mem_ready_i is deliberately not looked at here.
               if (grant_dm) begin
                  state       <= DM_BUSY;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
                  wait_cnt    <= '0;
               end else if (grant_if) begin
                  state       <= IF_BUSY;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  wait_cnt    <= '0;
               end
            end
            IF_BUSY, IF_DROP, DM_BUSY: begin
               if (mem_ready_i) begin
                  state     <= IDLE;
                  mem_req_o <= 1'b0;
                  // A flush landing on the completion cycle still cancels.
                  if (state == IF_BUSY && !if_flush_i) begin
                     if_ack_o   <= 1'b1;
                     if_rdata_o <= mem_rdata_i;
                  end
                  if (state == DM_BUSY) begin
                     dm_ack_o   <= 1'b1;
                     dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                  end
               end else begin
                  wait_cnt <= wait_inc;
                  if (timeout_hit) begin
                     fault_o   <= 1'b1;
                     state     <= IDLE;
                     mem_req_o <= 1'b0;
                  end else if (state == IF_BUSY && if_flush_i) begin
                     state <= IF_DROP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: directed scenarios plus randomized request
// mixes checked against a simple transaction-order model and a word memory.
module tb_mem_port_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i, if_flush_i, dm_req_i, dm_we_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
   logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, fault_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic        mem_ready_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.TIMEOUT(TMO), .DM_PRIORITY(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
      .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
      .stall_o(stall_o), .fault_o(fault_o)
   );

   always #5 clk_i = ~clk_i;

   // Memory environment: answers mem_ready_i after mem_lat cycles of
   // mem_req_o (0 = never), logs each command and flags unstable commands.
   logic [31:0] mem_arr [0:15];
   logic [31:0] ref_mem [0:15];
   int unsigned mem_lat     = 1;
   bit          stray_ready = 1'b0;
   int unsigned busy_cnt    = 0;
   bit          unstable    = 1'b0;
   logic [31:0] cmd_addr_q  [$];
   logic        cmd_we_q    [$];
   logic [31:0] cmd_wdata_q [$];
   logic [31:0] hold_addr, hold_wdata;
   logic        hold_we;

   always @(negedge clk_i) begin
      if (rst_i !== 1'b1) begin
         busy_cnt    = 0;
         mem_ready_i = 1'b0;
      end else if (mem_req_o === 1'b1) begin
         if (busy_cnt == 0) begin
            cmd_addr_q.push_back(mem_addr_o);
            cmd_we_q.push_back(mem_we_o);
            cmd_wdata_q.push_back(mem_wdata_o);
            hold_addr  = mem_addr_o;
            hold_we    = mem_we_o;
            hold_wdata = mem_wdata_o;
         end else if (mem_addr_o !== hold_addr || mem_we_o !== hold_we || mem_wdata_o !== hold_wdata) begin
            unstable = 1'b1;
         end
         busy_cnt++;
         if (mem_lat != 0 && busy_cnt == mem_lat) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = mem_arr[mem_addr_o[5:2]];
            if (mem_we_o) mem_arr[mem_addr_o[5:2]] = mem_wdata_o;
         end else begin
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
         end
      end else begin
         busy_cnt    = 0;
         mem_ready_i = stray_ready;
         mem_rdata_i = $urandom;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic poke(input int unsigned idx, input logic [31:0] val);
      mem_arr[idx] = val;
      ref_mem[idx] = val;
   endtask

   task automatic clear_cmds();
      cmd_addr_q.delete();
      cmd_we_q.delete();
      cmd_wdata_q.delete();
      unstable = 1'b0;
   endtask

   // Runs budget cycles, dropping each request on its ack and recording ack
   // counts, cycle indices (1 = first edge after the call) and data.
   task automatic run_reqs(input int budget,
                           output int ifc, output logic [31:0] ifd, output int ifn,
                           output int dmc, output logic [31:0] dmd, output int dmn,
                           output logic rq_after, output logic [31:0] ad_after);
      ifc = -1; dmc = -1; ifn = 0; dmn = 0; ifd = '0; dmd = '0;
      rq_after = 1'b0; ad_after = '0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk_i);
         if (dmc > 0 && c == dmc + 1) begin
            rq_after = mem_req_o;
            ad_after = mem_addr_o;
         end
         if (if_ack_o === 1'b1) begin ifn++; ifc = c; ifd = if_rdata_o; if_req_i = 1'b0; end
         if (dm_ack_o === 1'b1) begin dmn++; dmc = c; dmd = dm_rdata_o; dm_req_i = 1'b0; end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_lat = 1; stray_ready = 1'b0;
      for (int i = 0; i < 16; i++) poke(i, $urandom);
      repeat (3) @(negedge clk_i);
      n_checks++;
      if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, fault_o, stall_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, fault_o, stall_o});
      end
      n_checks++;
      if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o});
      end
   endtask

   task automatic test_fetch();
      poke(4, 32'h00A00093);
      mem_lat = 3;
      clear_cmds();
      // Released together with the request: grant on the first active edge.
      rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h10;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk_i);
         n_checks++;
         if (stall_o !== 1'b1 || if_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_stall c=%0d: stall=%b ack=%b expected stall=1 ack=0", c, stall_o, if_ack_o);
         end
         if (c > 0) begin
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin
               n_fail++;
               $display("FAIL fetch_cmd c=%0d: req=%b addr=%h we=%b expected 1 00000010 0", c, mem_req_o, mem_addr_o, mem_we_o);
            end
         end
      end
      @(negedge clk_i);
      n_checks++;
      if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h00A00093 || stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_ack: ack=%b data=%h stall=%b req=%b expected 1 00a00093 0 0", if_ack_o, if_rdata_o, stall_o, mem_req_o);
      end
      if_req_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (if_ack_o !== 1'b0 || mem_req_o !== 1'b0 || cmd_addr_q.size() != 1 || unstable) begin
         n_fail++;
         $display("FAIL fetch_after: ack=%b req=%b cmds=%0d unstable=%b expected 0 0 1 0", if_ack_o, mem_req_o, cmd_addr_q.size(), unstable);
      end
   endtask

   task automatic test_priority();
      int ifc, ifn, dmc, dmn;
      logic [31:0] ifd, dmd, ad_after, a, b;
      logic rq_after;
      a = $urandom; b = $urandom;
      poke(1, a); poke(6, b);
      mem_lat = 2;
      clear_cmds();
      if_req_i = 1'b1; if_addr_i = 32'h18;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h4; dm_wdata_i = $urandom;
      run_reqs(16, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
      n_checks++;
      if (dmn != 1 || dmc != 3 || dmd !== a) begin
         n_fail++;
         $display("FAIL prio_dm: n=%0d cyc=%0d data=%h expected 1 3 %h", dmn, dmc, dmd, a);
      end
      n_checks++;
      if (ifn != 1 || ifc != 6 || ifd !== b) begin
         n_fail++;
         $display("FAIL prio_if: n=%0d cyc=%0d data=%h expected 1 6 %h", ifn, ifc, ifd, b);
      end
      n_checks++;
      if (rq_after !== 1'b1 || ad_after !== 32'h18) begin
         n_fail++;
         $display("FAIL prio_regrant: req=%b addr=%h expected 1 00000018", rq_after, ad_after);
      end
      n_checks++;
      if (cmd_addr_q.size() != 2 || cmd_addr_q[0] !== 32'h4 || cmd_addr_q[1] !== 32'h18 || unstable) begin
         n_fail++;
         $display("FAIL prio_seq: cmds=%0d unstable=%b expected 2 cmds 00000004,00000018 stable", cmd_addr_q.size(), unstable);
      end
   endtask

   task automatic test_store();
      int ifc, ifn, dmc, dmn;
      logic [31:0] ifd, dmd, ad_after;
      logic rq_after;
      poke(8, 32'h12345678);
      mem_lat = 2;
      clear_cmds();
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEADBEEF;
      run_reqs(10, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
      ref_mem[8] = 32'hDEADBEEF;
      n_checks++;
      if (dmn != 1 || dmc != 3 || dmd !== 32'h0 || ifn != 0) begin
         n_fail++;
         $display("FAIL store_ack: n=%0d cyc=%0d rdata=%h ifn=%0d expected 1 3 0 0", dmn, dmc, dmd, ifn);
      end
      n_checks++;
      if (cmd_addr_q.size() != 1 || cmd_addr_q[0] !== 32'h20 || cmd_we_q[0] !== 1'b1 || cmd_wdata_q[0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL store_cmd: cmds=%0d expected one store of deadbeef to 00000020", cmd_addr_q.size());
      end
   endtask

   task automatic test_flush();
      int ifc, ifn, dmc, dmn, acks;
      logic [31:0] ifd, dmd, ad_after;
      logic rq_after;
      mem_lat = 5;
      clear_cmds();
      if_req_i = 1'b1; if_addr_i = 32'h30;
      repeat (2) @(negedge clk_i);
      if_flush_i = 1'b1;
      #1;
      n_checks++;
      if (stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_stall0: stall=%b expected 1", stall_o); end
      @(negedge clk_i);
      if_flush_i = 1'b0; if_req_i = 1'b0;
      #1;
      for (int c = 3; c <= 5; c++) begin
         if (c > 3) @(negedge clk_i);
         n_checks++;
         if (stall_o !== 1'b1 || if_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drop c=%0d: stall=%b ack=%b req=%b expected 1 0 1", c, stall_o, if_ack_o, mem_req_o);
         end
      end
      acks = 0;
      for (int c = 6; c <= 10; c++) begin
         @(negedge clk_i);
         if (if_ack_o === 1'b1) acks++;
         if (c == 6) begin
            n_checks++;
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
               n_fail++;
               $display("FAIL flush_idle: stall=%b req=%b expected 0 0", stall_o, mem_req_o);
            end
         end
      end
      n_checks++;
      if (acks != 0 || cmd_addr_q.size() != 1) begin
         n_fail++;
         $display("FAIL flush_noack: acks=%0d cmds=%0d expected 0 1", acks, cmd_addr_q.size());
      end
      // Flush in IDLE hides a same-cycle fetch request.
      if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 32'h34;
      @(negedge clk_i);
      n_checks++;
      if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_req: req=%b expected 0", mem_req_o); end
      if_req_i = 1'b0;
      // Flush during a data access changes nothing.
      mem_lat = 3;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h8;
      run_reqs(8, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
      if_flush_i = 1'b0;
      n_checks++;
      if (dmn != 1 || dmc != 4 || dmd !== ref_mem[2]) begin
         n_fail++;
         $display("FAIL flush_dm: n=%0d cyc=%0d data=%h expected 1 4 %h", dmn, dmc, dmd, ref_mem[2]);
      end
   endtask

   task automatic test_stray_ready();
      int ifc, ifn, dmc, dmn, acks;
      logic [31:0] ifd, dmd, ad_after;
      logic rq_after;
      stray_ready = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (if_ack_o === 1'b1 || dm_ack_o === 1'b1 || mem_req_o !== 1'b0) acks++;
      end
      n_checks++;
      if (acks != 0) begin n_fail++; $display("FAIL stray_idle: bad cycles=%0d expected 0", acks); end
      mem_lat = 2;
      if_req_i = 1'b1; if_addr_i = 32'h3C;
      run_reqs(8, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
      stray_ready = 1'b0;
      n_checks++;
      if (ifn != 1 || ifc != 3 || ifd !== ref_mem[15] || dmn != 0) begin
         n_fail++;
         $display("FAIL stray_fetch: n=%0d cyc=%0d data=%h dmn=%0d expected 1 3 %h 0", ifn, ifc, ifd, dmn, ref_mem[15]);
      end
   endtask

   task automatic test_timeout();
      int ifc, ifn, dmc, dmn, acks;
      logic [31:0] ifd, dmd, ad_after;
      logic rq_after, exp_f, exp_r;
      mem_lat = 0;
      clear_cmds();
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h8;
      acks = 0;
      for (int c = 1; c <= int'(TMO) + 4; c++) begin
         @(negedge clk_i);
         if (dm_ack_o === 1'b1 || if_ack_o === 1'b1) acks++;
         exp_f = (c >= int'(TMO) + 1);
         exp_r = (c <= int'(TMO));
         n_checks++;
         if ({fault_o, mem_req_o} !== {exp_f, exp_r}) begin
            n_fail++;
            $display("FAIL timeout c=%0d: fault,req=%b%b expected %b%b", c, fault_o, mem_req_o, exp_f, exp_r);
         end
         if (c == int'(TMO) + 1) dm_req_i = 1'b0;
      end
      n_checks++;
      if (acks != 0) begin n_fail++; $display("FAIL timeout_noack: acks=%0d expected 0", acks); end
      mem_lat = 2;
      if_req_i = 1'b1; if_addr_i = 32'h10;
      run_reqs(8, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
      n_checks++;
      if (ifn != 1 || ifd !== ref_mem[4] || fault_o !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_sticky: n=%0d data=%h fault=%b expected 1 %h 1", ifn, ifd, fault_o, ref_mem[4]);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      mem_lat = 4;
      clear_cmds();
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'hC;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hC) begin
         n_fail++;
         $display("FAIL rstmid_busy: req=%b addr=%h expected 1 0000000c", mem_req_o, mem_addr_o);
      end
      rst_i = 1'b0;
      #1;
      n_checks++;
      if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, fault_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_ctrl: got %b expected 00000", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, fault_o});
      end
      n_checks++;
      if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'd0) begin
         n_fail++;
         $display("FAIL rstmid_data: got %h expected 0", {mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o});
      end
      @(negedge clk_i);
      dm_req_i = 1'b0; rst_i = 1'b1;
      bad = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (dm_ack_o !== 1'b0 || mem_req_o !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_after: bad cycles=%0d expected 0", bad); end
   endtask

   task automatic test_random();
      int ifc, ifn, dmc, dmn, e_ifc, e_dmc, e_ifn, e_dmn, e_n;
      logic [31:0] ifd, dmd, ad_after, e_ifd, e_dmd, wd;
      logic [31:0] e_addr [2];
      logic        e_we [2];
      logic rq_after, we, cmd_ok;
      int unsigned mode, lat, ifi, dmi;
      for (int it = 0; it < 60; it++) begin
         mode = $urandom_range(1, 3);
         lat  = $urandom_range(1, 4);
         ifi  = $urandom_range(0, 15);
         dmi  = $urandom_range(0, 15);
         we   = 1'($urandom_range(0, 1));
         wd   = $urandom;
         // Model: data port first when both ask; each access takes lat
         // cycles plus one for the ack, the next grant issued in the ack cycle.
         e_n = 0; e_ifn = 0; e_dmn = 0; e_ifc = -1; e_dmc = -1; e_ifd = '0; e_dmd = '0;
         if ((mode & 2) != 0) begin
            e_dmn = 1; e_dmc = int'(lat) + 1;
            e_dmd = we ? 32'h0 : ref_mem[dmi];
            if (we) ref_mem[dmi] = wd;
            e_addr[e_n] = 32'(dmi * 4); e_we[e_n] = we; e_n++;
         end
         if ((mode & 1) != 0) begin
            e_ifn = 1; e_ifc = (e_n == 1) ? 2 * int'(lat) + 2 : int'(lat) + 1;
            e_ifd = ref_mem[ifi];
            e_addr[e_n] = 32'(ifi * 4); e_we[e_n] = 1'b0; e_n++;
         end
         mem_lat = lat;
         clear_cmds();
         if_req_i = ((mode & 1) != 0); if_addr_i = 32'(ifi * 4);
         dm_req_i = ((mode & 2) != 0); dm_we_i = we; dm_addr_i = 32'(dmi * 4); dm_wdata_i = wd;
         run_reqs(14, ifc, ifd, ifn, dmc, dmd, dmn, rq_after, ad_after);
         n_checks++;
         if (ifn != e_ifn || ifc != e_ifc || ifd !== e_ifd) begin
            n_fail++;
            $display("FAIL rand_if it=%0d: n=%0d cyc=%0d data=%h expected %0d %0d %h", it, ifn, ifc, ifd, e_ifn, e_ifc, e_ifd);
         end
         n_checks++;
         if (dmn != e_dmn || dmc != e_dmc || dmd !== e_dmd) begin
            n_fail++;
            $display("FAIL rand_dm it=%0d: n=%0d cyc=%0d data=%h expected %0d %0d %h", it, dmn, dmc, dmd, e_dmn, e_dmc, e_dmd);
         end
         cmd_ok = (cmd_addr_q.size() == e_n) && !unstable;
         for (int k = 0; k < e_n && cmd_ok; k++) begin
            if (cmd_addr_q[k] !== e_addr[k] || cmd_we_q[k] !== e_we[k]) cmd_ok = 1'b0;
            if (e_we[k] && cmd_wdata_q[k] !== wd) cmd_ok = 1'b0;
         end
         n_checks++;
         if (!cmd_ok) begin
            n_fail++;
            $display("FAIL rand_cmd it=%0d: cmds=%0d unstable=%b expected %0d stable commands in model order", it, cmd_addr_q.size(), unstable, e_n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_flush();
      test_stray_ready();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the maximum number of cycles a memory access may wait for mem_ready_i before the fault flag is set (range 1..1023).
REQ-002 The block SHALL have parameter DM_PRIORITY, default 1: 1 = data port wins simultaneous requests, 0 = instruction port wins.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port if_req_i, input, 1 bit: instruction-fetch request, level, held until if_ack_o.
REQ-006 The block SHALL have port if_addr_i, input, 32 bits: fetch byte address.
REQ-007 The block SHALL have port if_flush_i, input, 1 bit: cancels the outstanding fetch (branch taken).
REQ-008 The block SHALL have port if_ack_o, output, 1 bit: one-cycle fetch completion pulse.
REQ-009 The block SHALL have port if_rdata_o, output, 32 bits: fetched instruction, valid while if_ack_o=1.
REQ-010 The block SHALL have port dm_req_i, input, 1 bit: data request, level, held until dm_ack_o.
REQ-011 The block SHALL have port dm_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-012 The block SHALL have port dm_addr_i, input, 32 bits: data byte address.
REQ-013 The block SHALL have port dm_wdata_i, input, 32 bits: store data.
REQ-014 The block SHALL have port dm_ack_o, output, 1 bit: one-cycle data completion pulse.
REQ-015 The block SHALL have port dm_rdata_o, output, 32 bits: load data, valid while dm_ack_o=1.
REQ-016 The block SHALL have port mem_req_o, output, 1 bit: request to the shared single-port memory.
REQ-017 The block SHALL have ports mem_we_o (output, 1 bit), mem_addr_o (output, 32 bits) and mem_wdata_o (output, 32 bits): the memory command.
REQ-018 The block SHALL have port mem_rdata_i, input, 32 bits: memory read data, valid when mem_ready_i=1.
REQ-019 The block SHALL have port mem_ready_i, input, 1 bit: memory completion, one cycle.
REQ-020 The block SHALL have port stall_o, output, 1 bit: pipeline freeze, used for the PC/IF_ID stall and the control-bubble mux.
REQ-021 The block SHALL have port fault_o, output, 1 bit: sticky timeout flag.

Function
REQ-022 The FSM SHALL have the states IDLE, IF_BUSY, IF_DROP and DM_BUSY, and all outputs except stall_o SHALL be registered.
REQ-023 In IDLE, when a request is visible at cycle N, the FSM SHALL latch the address, we and wdata and enter the BUSY state at N+1, with mem_req_o=1 from N+1.
REQ-024 When if_req_i and dm_req_i are both high in IDLE, the grant SHALL follow DM_PRIORITY; the loser SHALL be served next, with no starvation by design because the pipeline is frozen.
REQ-025 mem_req_o and mem_addr_o/mem_we_o/mem_wdata_o SHALL stay stable until mem_ready_i is sampled high; mem_req_o SHALL drop in the following cycle.
REQ-026 If mem_ready_i is sampled high at cycle M in IF_BUSY or DM_BUSY, the block SHALL pulse the matching ack for exactly one cycle at M+1, with rdata = mem_rdata_i captured at M, and the FSM SHALL be in IDLE at M+1.
REQ-027 In the ack cycle, the acked requester SHALL be ignored for arbitration; the other pending requester MAY be granted in that same cycle.
REQ-028 On if_flush_i=1 while in IF_BUSY, the FSM SHALL go to IF_DROP; the memory access SHALL complete, but if_ack_o SHALL stay 0 and the data SHALL be discarded.
REQ-029 On if_flush_i=1 in IDLE, a same-cycle if_req_i SHALL be ignored.
REQ-030 if_flush_i SHALL have no effect in DM_BUSY.
REQ-031 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o) | (state==IF_DROP).
REQ-032 For stores, dm_rdata_o SHALL be 0 and dm_ack_o SHALL still pulse.
REQ-033 The wait counter (10 bits) SHALL clear on grant and increment each BUSY/IF_DROP cycle that has mem_ready_i=0.
REQ-034 When the wait counter reaches TIMEOUT, fault_o SHALL be set to 1, the FSM SHALL return to IDLE, mem_req_o SHALL drop, no ack SHALL be issued, and the counter SHALL saturate with no wrap.
REQ-035 fault_o SHALL clear only on reset.
REQ-036 A mem_ready_i pulse arriving in IDLE SHALL be ignored.

Reset
REQ-037 When rst_i=0, the block SHALL asynchronously set the FSM to IDLE and force mem_req_o, mem_we_o, if_ack_o, dm_ack_o and fault_o to 0, mem_addr_o/mem_wdata_o/if_rdata_o/dm_rdata_o to 0x00000000, and the wait counter to 0.
REQ-038 When reset asserts mid-access, the in-flight transaction SHALL be abandoned and no ack SHALL be issued after release.
REQ-039 The first grant after reset release SHALL be possible on the first rising edge at which rst_i=1.

Verification
REQ-040 The bench SHALL cover: fetch 0x00000010, memory ready after 3 cycles with 0x00A00093 -> if_ack_o=1 for one cycle with if_rdata_o=0x00A00093, and stall_o high for the 4 prior cycles.
REQ-041 The bench SHALL cover: simultaneous if_req_i and dm_req_i (load 0x00000004), DM_PRIORITY=1 -> data served first and dm_ack_o precedes if_ack_o, the second grant issued in the dm_ack cycle, and mem_addr_o sequence 0x4 then the fetch address.
REQ-042 The bench SHALL cover: store 0xDEADBEEF to 0x00000020 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, dm_ack_o pulse, and dm_rdata_o=0.
REQ-043 The bench SHALL cover: if_flush_i during IF_BUSY -> no if_ack_o, stall_o held until mem_ready_i, then IDLE.
REQ-044 The bench SHALL cover: mem_ready_i held 0 with TIMEOUT=8 -> fault_o=1 after 8 wait cycles, mem_req_o=0, no ack, and fault_o remains 1 until rst_i=0.
REQ-045 The bench SHALL cover: rst_i asserted during DM_BUSY -> outputs at reset values immediately, and no dm_ack_o after release.
